// File: rtl/run_controller_pkg.sv
// Shared definitions for the CPU run controller: state encoding, phase defaults
// and the phase-index width helper.
package run_controller_pkg;

  localparam int unsigned NumPhases  = 5;
  localparam int unsigned MemPhase   = 3;
  localparam int unsigned MemTimeout = 15;
  localparam int unsigned IcountW    = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStep,
    StFault
  } run_state_e;

  // Width of a binary index covering n phases (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_controller_phase_ring.sv
// One-hot phase rotator: shifts the single set bit up one position per enabled
// cycle, wrapping the top phase back to bit 0.
module run_controller_phase_ring #(
  parameter int unsigned NUM_PHASES = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic [NUM_PHASES-1:0] phase
);

  logic [NUM_PHASES-1:0] phase_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= NUM_PHASES'(1);
    end else if (enable) begin
      phase_q <= {phase_q[NUM_PHASES-2:0], phase_q[NUM_PHASES-1]};
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/run_controller.sv
// Phase sequencer for the multi-cycle CPU: run/pause and single-step from panel
// buttons, memory wait-states, halt on HLT and sticky fault on memory timeout.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = NumPhases,
  parameter int unsigned MEM_PHASE   = MemPhase,
  parameter int unsigned MEM_TIMEOUT = MemTimeout,
  parameter int unsigned ICOUNT_W    = IcountW
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_btn,
  input  logic                  step_btn,
  input  logic                  halt_insn,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic [NUM_PHASES-1:0] phase,
  output logic                  running,
  output logic                  halted,
  output logic                  fault,
  output logic [ICOUNT_W-1:0]   icount
);

  localparam int unsigned IdxW = idx_width(NUM_PHASES);
  localparam int unsigned TmoW = idx_width(MEM_TIMEOUT);

  localparam logic [IdxW-1:0] MemIdx  = IdxW'(MEM_PHASE);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_PHASES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

  run_state_e          state_q, state_d;
  logic                run_btn_q, step_btn_q;
  logic                stop_pend_q, stop_pend_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [ICOUNT_W-1:0] icount_q, icount_d;
  logic [IdxW-1:0]     phase_idx;
  logic                run_rise, step_rise, in_mem, mem_wait, adv, boundary;

  always_comb begin
    phase_idx = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (phase[i]) phase_idx = IdxW'(i);
    end
  end

  assign run_rise  = run_btn & ~run_btn_q;
  assign step_rise = step_btn & ~step_btn_q;
  assign running   = (state_q == StRun) || (state_q == StStep);
  assign halted    = (state_q == StIdle) || (state_q == StFault);
  assign fault     = (state_q == StFault);
  assign in_mem    = (phase_idx == MemIdx);
  assign mem_req   = running & in_mem;
  assign mem_wait  = mem_req & ~mem_ack;
  assign adv       = running & ~(in_mem & ~(mem_req & mem_ack));
  assign boundary  = adv & (phase_idx == LastIdx);
  assign icount    = icount_q;

  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    tmo_cnt_d   = tmo_cnt_q;
    icount_d    = icount_q;

    case (state_q)
      StIdle: begin
        if (run_rise) begin
          state_d = StRun;
        end else if (step_rise) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (run_rise) stop_pend_d = 1'b1;
      end
      default: ;
    endcase

    if (mem_wait) begin
      if (tmo_cnt_q == TmoLast) begin
        state_d = StFault;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    if (adv) tmo_cnt_d = '0;

    // Stops only take effect here, so IDLE is always entered at phase 0.
    if (boundary) begin
      icount_d = icount_q + 1'b1;
      if (halt_insn || (state_q == StStep) || stop_pend_q) begin
        state_d     = StIdle;
        stop_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      run_btn_q   <= 1'b0;
      step_btn_q  <= 1'b0;
      stop_pend_q <= 1'b0;
      tmo_cnt_q   <= '0;
      icount_q    <= '0;
    end else begin
      state_q     <= state_d;
      run_btn_q   <= run_btn;
      step_btn_q  <= step_btn;
      stop_pend_q <= stop_pend_d;
      tmo_cnt_q   <= tmo_cnt_d;
      icount_q    <= icount_d;
    end
  end

  run_controller_phase_ring #(
    .NUM_PHASES(NUM_PHASES)
  ) u_phase_ring (
    .clock (clock),
    .reset (reset),
    .enable(adv),
    .phase (phase)
  );

endmodule
